// File: rtl/count_sched_if.sv
// ============================================================================
// Module   : count_sched_if
// Purpose  : Requester and shared-counter signals of the count_sched block.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface count_sched_if #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [WIDTH-1:0]      cnt_out;
    logic                  cnt_rst;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;

    modport master (
        output req, len, cnt_out,
        input  cnt_rst, gnt, done, busy
    );

    modport slave (
        input  req, len, cnt_out,
        output cnt_rst, gnt, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/count_sched.sv
// ============================================================================
// Module   : count_sched
// Purpose  : Round-robin sharing of one clearable up-counter among requesters.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module count_sched #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4,
    parameter int INCR  = 1
) (
    input  logic          clk,
    input  logic          rst,
    count_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int               IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH:0]   c_incr     = (WIDTH+1)'(INCR);
    localparam logic [IDXW-1:0]  c_last     = IDXW'(NREQ - 1);
    localparam logic [IDXW:0]    c_nreq     = (IDXW+1)'(NREQ);
    localparam logic [NREQ-1:0]  c_one      = {{(NREQ-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [IDXW-1:0]    ptr_q, ptr_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]   len_q, len_d;

    logic [2*NREQ-1:0]  w_req2;
    logic [NREQ-1:0]    w_rot;
    logic [IDXW-1:0]    w_off;
    logic [IDXW:0]      w_sum;
    logic [IDXW-1:0]    w_sel;
    logic               w_any;
    logic [IDXW-1:0]    w_idx_inc;
    logic [WIDTH:0]     w_len_eff;
    logic [WIDTH:0]     w_cnt_next;
    logic               w_term;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        w_req2 = {bus.req, bus.req} >> ptr_q;
        w_rot  = w_req2[NREQ-1:0];
        w_off  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDXW'(k);
            end
        end
        w_sum = {1'b0, ptr_q} + {1'b0, w_off};
        w_sel = (w_sum >= c_nreq) ? IDXW'(w_sum - c_nreq) : IDXW'(w_sum);
        w_any = |bus.req;
    end

    // Terminal test is done one bit wider so cnt_out + INCR cannot wrap.
    always_comb begin
        w_idx_inc  = (idx_q == c_last) ? '0 : idx_q + 1'b1;
        w_len_eff  = (len_q == '0) ? c_incr : {1'b0, len_q};
        w_cnt_next = {1'b0, bus.cnt_out} + c_incr;
        w_term     = (w_cnt_next >= w_len_eff);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    state_d = S_RUN;
                    idx_d   = w_sel;
                    gnt_d   = c_one << w_sel;
                    len_d   = bus.len[w_sel*WIDTH +: WIDTH];
                end
            end
            S_RUN: begin
                // A dropped request wins over a simultaneous terminal count.
                if (!bus.req[idx_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = w_idx_inc;
                end else if (w_term) begin
                    state_d = S_DONE;
                    done_d  = c_one << idx_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                done_d  = '0;
                ptr_d   = w_idx_inc;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                done_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.cnt_rst = (state_q != S_RUN);

endmodule

`default_nettype wire
